// File: rtl/lsm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsm_sequencer: load/store-multiple sequencer (IA/IB/DA/DB, base writeback, |
// | S-bit CPSR restore). Optional macro: LSM_BASE_LOAD_WINS_EN.                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module lsm_sequencer #(
  parameter int NREGS  = 16,
  parameter int RNW    = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int STRIDE = 4
) (
  input  logic             clk,
  input  logic             Nrst,
  input  logic             flush,
  input  logic             start,
  input  logic             load,
  input  logic             up,
  input  logic             pre,
  input  logic             wb,
  input  logic             sbit,
  input  logic [RNW-1:0]   base_num,
  input  logic [AW-1:0]    base_val,
  input  logic [NREGS-1:0] reglist,
  output logic [AW-1:0]    busaddr,
  output logic             rd_req,
  output logic             wr_req,
  input  logic             rw_wait,
  output logic [DW-1:0]    wr_data,
  input  logic [DW-1:0]    rd_data,
  output logic [RNW-1:0]   st_read,
  input  logic [DW-1:0]    st_data,
  output logic             out_write_reg,
  output logic [RNW-1:0]   out_write_num,
  output logic [DW-1:0]    out_write_data,
  output logic             cpsr_restore,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [NREGS-1:0] c_one    = NREGS'(1);
  localparam logic [AW-1:0]    c_stride = AW'(STRIDE);
  localparam logic [RNW-1:0]   c_top    = RNW'(NREGS - 1);

  state_t r_state;
  state_t w_next;

  logic [NREGS-1:0] r_mask;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_final;
  logic             r_load;
  logic             r_wb;
  logic             r_sbit;
  logic [RNW-1:0]   r_base_num;
`ifdef LSM_BASE_LOAD_WINS_EN
  logic             r_base_hit;
`endif

  logic [RNW:0]     w_count;
  logic [AW-1:0]    w_span;
  logic [AW-1:0]    w_first;
  logic [AW-1:0]    w_final;
  logic [RNW-1:0]   w_cur;
  logic [NREGS-1:0] w_mask_next;
  logic             w_start;
  logic             w_any;
  logic             w_accept;
  logic             w_last;
  logic             w_exit;
  logic             w_take_wb;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NREGS; i++)
      w_count = w_count + {{RNW{1'b0}}, reglist[i]};
  end

  always_comb begin
    w_cur = '0;
    for (int i = NREGS - 1; i >= 0; i--)
      if (r_mask[i]) w_cur = RNW'(i);
  end

  // Decrementing modes still walk upward from the lowest address.
  assign w_span  = c_stride * AW'(w_count);
  assign w_first = up ? (pre ? base_val + c_stride : base_val)
                      : (pre ? base_val - w_span : base_val - w_span + c_stride);
  assign w_final = up ? base_val + w_span : base_val - w_span;

  assign w_start     = (r_state == S_IDLE) && start && !flush;
  assign w_any       = |r_mask;
  assign w_accept    = (r_state == S_XFER) && w_any && !rw_wait && !flush;
  assign w_mask_next = r_mask & ~(c_one << w_cur);
  assign w_last      = w_accept && (w_mask_next == '0);
  assign w_exit      = (r_state == S_XFER) && !flush && (!w_any || w_last);

`ifdef LSM_BASE_LOAD_WINS_EN
  assign w_take_wb = r_wb && !r_base_hit;
`else
  assign w_take_wb = r_wb;
`endif

  assign busy    = (r_state != S_IDLE);
  assign wr_data = st_data;

  always_ff @(posedge clk) begin
    if (!Nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    busaddr = '0;
    st_read = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_XFER;
      end
      S_XFER: begin
        busaddr = r_addr;
        st_read = w_cur;
        if (w_any && !flush) begin
          rd_req = r_load;
          wr_req = !r_load;
        end
        if (w_exit) w_next = w_take_wb ? S_WB : S_IDLE;
      end
      S_WB: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      r_mask         <= '0;
      r_addr         <= '0;
      r_final        <= '0;
      r_load         <= 1'b0;
      r_wb           <= 1'b0;
      r_sbit         <= 1'b0;
      r_base_num     <= '0;
`ifdef LSM_BASE_LOAD_WINS_EN
      r_base_hit     <= 1'b0;
`endif
      out_write_reg  <= 1'b0;
      out_write_num  <= '0;
      out_write_data <= '0;
      cpsr_restore   <= 1'b0;
      done           <= 1'b0;
    end else begin
      out_write_reg <= 1'b0;
      cpsr_restore  <= 1'b0;
      done          <= 1'b0;

      if (w_start) begin
        r_mask     <= reglist;
        r_addr     <= w_first;
        r_final    <= w_final;
        r_load     <= load;
        r_wb       <= wb;
        r_sbit     <= sbit;
        r_base_num <= base_num;
`ifdef LSM_BASE_LOAD_WINS_EN
        r_base_hit <= load && reglist[base_num];
`endif
      end

      if (w_accept) begin
        r_mask <= w_mask_next;
        r_addr <= r_addr + c_stride;
        if (r_load) begin
          out_write_reg  <= 1'b1;
          out_write_num  <= w_cur;
          out_write_data <= rd_data;
          cpsr_restore   <= r_sbit && (w_cur == c_top);
        end
      end

      if (w_exit && !w_take_wb) done <= 1'b1;

      if ((r_state == S_WB) && !flush) begin
        out_write_reg  <= 1'b1;
        out_write_num  <= r_base_num;
        out_write_data <= r_final;
        done           <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsm_sequencer.sv
`default_nettype none
// Directed bench for lsm_sequencer: scoreboard of expected bus transfers and
// regfile writes, checked by a negedge monitor with immediate assertions.
module tb_lsm_sequencer;

  logic        clk = 1'b0;
  logic        Nrst, flush, start, load, up, pre, wb, sbit, rw_wait;
  logic [3:0]  base_num;
  logic [31:0] base_val;
  logic [15:0] reglist;
  logic [31:0] busaddr, wr_data, rd_data, st_data, out_write_data;
  logic        rd_req, wr_req, out_write_reg, cpsr_restore, busy, done;
  logic [3:0]  st_read, out_write_num;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] data;
  } bus_t;
  typedef struct {
    logic [3:0]  num;
    logic [31:0] data;
    logic        cpsr;
  } wr_t;

  bus_t bus_q[$];
  wr_t  wr_q[$];

  always #5 clk = ~clk;

  assign rd_data = busaddr ^ 32'hD000_0000;
  assign st_data = 32'hA500_0000 | {28'd0, st_read};

  lsm_sequencer dut (
    .clk(clk), .Nrst(Nrst), .flush(flush), .start(start), .load(load), .up(up),
    .pre(pre), .wb(wb), .sbit(sbit), .base_num(base_num), .base_val(base_val),
    .reglist(reglist), .busaddr(busaddr), .rd_req(rd_req), .wr_req(wr_req),
    .rw_wait(rw_wait), .wr_data(wr_data), .rd_data(rd_data), .st_read(st_read),
    .st_data(st_data), .out_write_reg(out_write_reg), .out_write_num(out_write_num),
    .out_write_data(out_write_data), .cpsr_restore(cpsr_restore), .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (Nrst === 1'b1) begin
      if ((rd_req || wr_req) && !rw_wait) begin
        if (bus_q.size() == 0) chk("bus_unexpected", {rd_req, busaddr}, 64'd0);
        else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_addr", busaddr, b.addr);
          chk("bus_dir", {rd_req, wr_req}, {b.rd, !b.rd});
          if (!b.rd) chk("bus_wdata", wr_data, b.data);
        end
      end
      if (out_write_reg || cpsr_restore) begin
        if (wr_q.size() == 0) chk("wr_unexpected", {out_write_num, out_write_data}, 64'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_en", out_write_reg, 1'b1);
          chk("wr_num", out_write_num, w.num);
          chk("wr_data", out_write_data, w.data);
          chk("cpsr", cpsr_restore, w.cpsr);
        end
      end
    end
  end

  task automatic run_op(input string tag, input logic ld, input logic up_i, input logic pre_i,
                        input logic wb_i, input logic sb, input logic [3:0] bn,
                        input logic [31:0] bv, input logic [15:0] rl, input int stall);
    int          n, lat, k, stall_left;
    logic [31:0] a, first, fin;
    bit          do_wb;
    n = $countones(rl);
    if (up_i) a = pre_i ? bv + 32'd4 : bv;
    else      a = pre_i ? bv - 32'(4 * n) : bv - 32'(4 * n) + 32'd4;
    first = a;
    fin   = up_i ? bv + 32'(4 * n) : bv - 32'(4 * n);
    for (int r = 0; r < 16; r++) begin
      if (rl[r]) begin
        bus_q.push_back('{addr: a, rd: ld, data: 32'hA500_0000 + 32'(r)});
        if (ld) wr_q.push_back('{num: 4'(r), data: a ^ 32'hD000_0000, cpsr: sb && (r == 15)});
        a = a + 32'd4;
      end
    end
    do_wb = wb_i;
`ifdef LSM_BASE_LOAD_WINS_EN
    if (ld && rl[bn]) do_wb = 1'b0;
`endif
    if (do_wb) wr_q.push_back('{num: bn, data: fin, cpsr: 1'b0});
    lat = 1 + ((n == 0) ? 1 : n) + (do_wb ? 1 : 0) + stall;

    load = ld; up = up_i; pre = pre_i; wb = wb_i; sbit = sb;
    base_num = bn; base_val = bv; reglist = rl; start = 1'b1;
    tick();
    start = 1'b0;
    reglist = 16'hFFFF;
    base_val = 32'hDEAD_BEEF;
    k = 1;
    stall_left = stall;
    chk({tag, "_busy"}, busy, 1'b1);
    while (done !== 1'b1 && k < 64) begin
      if (stall_left > 0 && (rd_req || wr_req)) begin
        rw_wait = 1'b1;
        stall_left--;
        chk({tag, "_held_addr"}, busaddr, first);
      end else rw_wait = 1'b0;
      tick();
      k++;
    end
    rw_wait = 1'b0;
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_bus_q_left"}, bus_q.size(), 0);
    chk({tag, "_wr_q_left"}, wr_q.size(), 0);
  endtask

  initial begin
    Nrst = 1'b0; flush = 1'b0; start = 1'b1; load = 1'b1; up = 1'b1; pre = 1'b0;
    wb = 1'b1; sbit = 1'b0; rw_wait = 1'b0; base_num = 4'd0; base_val = 32'h100;
    reglist = 16'h00FF;
    tick();
    tick();
    chk("rst_req", {rd_req, wr_req}, 2'b00);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_wr", {out_write_reg, cpsr_restore}, 2'b00);
    chk("rst_addr", busaddr, 32'd0);
    chk("rst_sel", {st_read, out_write_num}, 8'd0);
    chk("rst_wdata", out_write_data, 32'd0);
    start = 1'b0;
    Nrst  = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    run_op("ldmia",   1, 1, 0, 1, 0, 4'd13, 32'h0000_1000, 16'h000B, 0);
    run_op("stmdb",   0, 0, 1, 1, 0, 4'd13, 32'h0000_2000, 16'hC001, 0);
    run_op("ldmib_w", 1, 1, 1, 0, 0, 4'd7,  32'h0000_3000, 16'h0006, 3);
    run_op("ldmda_s", 1, 0, 0, 0, 1, 4'd4,  32'h0000_4000, 16'h8000, 0);
    run_op("empty",   1, 1, 0, 1, 0, 4'd5,  32'h0000_0040, 16'h0000, 0);
    run_op("stmib",   0, 1, 1, 1, 0, 4'd1,  32'hFFFF_FFF8, 16'h00F0, 0);
    run_op("stm_wait",0, 0, 0, 0, 0, 4'd3,  32'h0000_0800, 16'h0300, 2);
    run_op("basewin", 1, 1, 0, 1, 0, 4'd2,  32'h0000_6000, 16'h0004, 0);

    // Flush on the second of four loads: only r0 completes.
    bus_q.push_back('{addr: 32'h5000, rd: 1'b1, data: 32'h0});
    wr_q.push_back('{num: 4'd0, data: 32'h5000 ^ 32'hD000_0000, cpsr: 1'b0});
    load = 1; up = 1; pre = 0; wb = 1; sbit = 0; base_num = 4'd9;
    base_val = 32'h5000; reglist = 16'h000F; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("flush_req", {rd_req, wr_req}, 2'b00);
    tick();
    flush = 1'b0;
    chk("flush_idle", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("flush_no_done", done, 1'b0);
      chk("flush_no_req", {rd_req, wr_req, out_write_reg}, 3'b000);
      tick();
    end
    chk("flush_bus_q", bus_q.size(), 0);
    chk("flush_wr_q", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Parametrised load/store-multiple sequencer for the memory stage. It replaces the fixed 16-register LDM/STM path.
- Walks an N-bit register list and issues one bus word transfer per set bit, in ascending register order, at ARM-correct ascending addresses for all four modes (IA/IB/DA/DB).
- Performs optional base writeback, and flags an SPSR→CPSR restore when the S bit is set and the top register is loaded.
- Sits between decode/execute operands, the data bus, and the regfile read/write ports.

Parameters:
NREGS, 16, number of registers in list (power of two, 2..32)
RNW, 4, register number width (log2 NREGS)
AW, 32, bus address width
DW, 32, data width
STRIDE, 4, byte address increment per transfer

Ports:
clk  in  1  clock
Nrst  in  1  synchronous active-low reset
flush  in  1  abort current operation
start  in  1  begin operation (sampled in IDLE only)
load  in  1  1=LDM, 0=STM
up  in  1  1=increment, 0=decrement
pre  in  1  1=before (IB/DB), 0=after (IA/DA)
wb  in  1  base writeback enable
sbit  in  1  S bit
base_num  in  RNW  base register number
base_val  in  AW  base register value
reglist  in  NREGS  register list, bit i = register i
busaddr  out  AW  bus address
rd_req  out  1  read request
wr_req  out  1  write request
rw_wait  in  1  bus stall; request held while high
wr_data  out  DW  store data (= st_data)
rd_data  in  DW  load data, valid when rd_req && !rw_wait
st_read  out  RNW  regfile read select
st_data  in  DW  regfile read data (combinational)
out_write_reg  out  1  regfile write enable
out_write_num  out  RNW  regfile write register
out_write_data  out  DW  regfile write data
cpsr_restore  out  1  one-cycle pulse: copy SPSR to CPSR
busy  out  1  operation in progress (stage must stall)
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (Nrst=0 at posedge): state IDLE. rd_req, wr_req, out_write_reg, cpsr_restore, busy and done are all 0; busaddr, st_read and out_write_* are 0. Nrst overrides flush and start.
- States: IDLE, XFER, WB.
- IDLE: when start=1 and flush=0:
  - latch reglist into the pending mask and compute n = popcount(reglist).
  - latch the first address: IA = base; IB = base+STRIDE; DA = base−STRIDE·n+STRIDE; DB = base−STRIDE·n.
  - latch the final base: up ? base+STRIDE·n : base−STRIDE·n (AW-bit wraparound).
  - go to XFER; busy=1 from the next cycle.
- start is ignored while not in IDLE.
- XFER (combinational outputs):
  - cur = lowest set bit of the pending mask; st_read = cur; busaddr = current address.
  - rd_req = load, wr_req = !load.
- XFER, when rw_wait=0 (transfer accepted):
  - clear bit cur; address += STRIDE.
  - if load, next cycle: out_write_reg=1, out_write_num=cur, out_write_data=rd_data (registered).
  - if load and sbit and cur = NREGS−1: cpsr_restore pulses in that same registered cycle.
- XFER, when rw_wait=1: all request outputs are held stable and nothing advances.
- XFER exit, on the accepted last transfer: go to WB if wb, else go to IDLE and pulse done the next cycle.
- Empty reglist (n=0): XFER issues no request and exits immediately. WB, if taken, writes base_val unchanged.
- WB: one cycle. Registered write of base_num ← final base on the next edge. Then IDLE, with done pulsing together with that write.
- Throughput: one transfer per cycle with no wait states. Total latency = 1 + n + wb cycles from start to done.
- flush: in any state, the next state is IDLE.
  - rd_req and wr_req are forced low in the flush cycle.
  - No regfile write or done is produced for that cycle or after it.
  - Writes already registered still complete.
- No other source of out_write_reg exists. Writes occur only on the cycle after an accepted load, or the cycle after WB.

Optional Feature:
LSM_BASE_LOAD_WINS_EN
- Defined: for LDM where reglist[base_num]=1, WB is skipped and the loaded base value stands; done pulses from XFER exit.
- Undefined: WB always executes when wb=1, and the computed base overwrites the loaded value.
- STM behaviour is identical either way: the stored base value is the original base_val.

Test Plan:
- LDMIA, base=0x1000, list=0x000B, wb=1, no waits → reads at 0x1000/0x1004/0x1008 into r0, r1, r3; r(base) ← 0x100C; done 5 cycles after start.
- STMDB, base=0x2000, list=0xC001 → writes r0, r14, r15 at 0x1FF4/0x1FF8/0x1FFC; with wb, base ← 0x1FF4.
- LDMIB, list=0x0006, rw_wait high 3 cycles on the first transfer → busaddr=base+4 held steady, no regfile write until accept; total latency +3.
- LDMDA with sbit=1, list=0x8000 → one read at base; r15 written; cpsr_restore pulses in the same cycle.
- Empty list, wb=1, base=0x40 → no bus requests; base ← 0x40; done 3 cycles after start.
- Flush asserted during the second of four transfers → no further requests, no WB, no done; IDLE next cycle. Separately, LDMIA base=r2, list=0x0004, wb=1: r2 = loaded data with LSM_BASE_LOAD_WINS_EN, r2 = base+4 without.
